eq_band_mixer: RTL and testbench

EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

---
 rtl/eq_pkg.sv | 23 ++
 rtl/eq_gain_bank.sv | 70 +++++++
 rtl/eq_band_mixer.sv | 164 ++++++++++++++++
 tb/tb_eq_band_mixer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared FSM state type, default parameters and unity-gain helper for the equaliser band mixer.
// EQ_BAND_MIXER_RAMP_EN (when defined) turns on one-LSB-per-sample gain ramping in eq_gain_bank.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int DEF_NUM_BANDS = 3;
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_GAIN_W    = 8;
  localparam int DEF_GAIN_FRAC = 7;

  function automatic int unity_gain(input int frac);
    return 1 << frac;
  endfunction

  localparam int GAIN_UNITY = 1 << DEF_GAIN_FRAC;

endpackage

// File: rtl/eq_gain_bank.sv
// Per-band target/effective gain registers with write decode; effective gains update only when i_step pulses.
// EQ_BAND_MIXER_RAMP_EN: effective gain walks one LSB toward target per step; otherwise it tracks target directly.
module eq_gain_bank
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int IDX_W     = $clog2(NUM_BANDS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_wr_en,
  input  logic [IDX_W-1:0]            i_wr_band,
  input  logic [GAIN_W-1:0]           i_wr_data,
  input  logic                        i_step,
  output logic [NUM_BANDS*GAIN_W-1:0] o_gain_eff
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

`ifndef EQ_BAND_MIXER_RAMP_EN
  logic w_step_unused;
  assign w_step_unused = i_step;
`endif

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    logic              w_wr_hit;
    logic [GAIN_W-1:0] r_tgt;

    // Out-of-range band indices never match any band, so those writes drop.
    assign w_wr_hit = i_wr_en && (i_wr_band == IDX_W'(b));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_tgt <= UNITY;
      end else if (w_wr_hit) begin
        r_tgt <= i_wr_data;
      end
    end

`ifdef EQ_BAND_MIXER_RAMP_EN
    logic [GAIN_W-1:0] r_eff;
    logic [GAIN_W-1:0] w_eff_nxt;

    always_comb begin
      w_eff_nxt = r_eff;
      if (r_eff < r_tgt) begin
        w_eff_nxt = r_eff + 1'b1;
      end else if (r_eff > r_tgt) begin
        w_eff_nxt = r_eff - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_eff <= UNITY;
      end else if (i_step) begin
        r_eff <= w_eff_nxt;
      end
    end

    // The stepped value is what the accepted sample must see.
    assign o_gain_eff[b*GAIN_W +: GAIN_W] = w_eff_nxt;
`else
    assign o_gain_eff[b*GAIN_W +: GAIN_W] = r_tgt;
`endif
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Weighted sum of NUM_BANDS band samples through one shared multiplier; out_valid NUM_BANDS+2 cycles after accept.
// in_ready only in IDLE, result held until out_ready; EQ_BAND_MIXER_RAMP_EN selects ramped gains.
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_BANDS*DATA_W-1:0]  band_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         gain_wr_en,
  input  logic [$clog2(NUM_BANDS)-1:0] gain_wr_band,
  input  logic [GAIN_W-1:0]            gain_wr_data,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sat_flag
);

  localparam int IDX_W  = $clog2(NUM_BANDS);
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = DATA_W + GAIN_W + IDX_W + 1;

  localparam logic [GAIN_W-1:0]       UNITY   = GAIN_W'(unity_gain(GAIN_FRAC));
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (GAIN_FRAC - 1));
  localparam logic signed [ACC_W-1:0] OUT_MAX = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_accept;
  logic                        w_last;

  logic signed [DATA_W-1:0]    r_smp  [NUM_BANDS];
  logic        [GAIN_W-1:0]    r_gain [NUM_BANDS];
  logic [NUM_BANDS*GAIN_W-1:0] w_gain_eff;
  logic        [IDX_W-1:0]     r_idx;
  logic signed [ACC_W-1:0]     r_acc;
  logic        [DATA_W-1:0]    r_out_data;
  logic                        r_sat;

  logic signed [DATA_W-1:0]    w_smp;
  logic signed [PROD_W-1:0]    w_smp_ext;
  logic signed [PROD_W-1:0]    w_gain_ext;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_rnd;
  logic signed [ACC_W-1:0]     w_shift;
  logic                        w_clip_hi;
  logic                        w_clip_lo;

  eq_gain_bank #(
    .NUM_BANDS (NUM_BANDS),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC),
    .IDX_W     (IDX_W)
  ) u_gain_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_en    (gain_wr_en),
    .i_wr_band  (gain_wr_band),
    .i_wr_data  (gain_wr_data),
    .i_step     (w_accept),
    .o_gain_eff (w_gain_eff)
  );

  assign w_last = (r_idx == IDX_W'(NUM_BANDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_last) begin
          w_state_nxt = ST_SCALE;
        end
      end
      ST_SCALE: begin
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Gain is unsigned, so it enters the signed product with a zero sign bit.
  assign w_smp      = r_smp[r_idx];
  assign w_smp_ext  = {{(GAIN_W+1){w_smp[DATA_W-1]}}, w_smp};
  assign w_gain_ext = {{(DATA_W+1){1'b0}}, r_gain[r_idx]};
  assign w_prod     = w_smp_ext * w_gain_ext;
  assign w_prod_ext = {{IDX_W{w_prod[PROD_W-1]}}, w_prod};

  assign w_rnd     = r_acc + RND;
  assign w_shift   = w_rnd >>> GAIN_FRAC;
  assign w_clip_hi = (w_shift > OUT_MAX);
  assign w_clip_lo = (w_shift < OUT_MIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_smp[b]  <= '0;
        r_gain[b] <= UNITY;
      end
      r_idx      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          r_smp[b]  <= band_data[b*DATA_W +: DATA_W];
          r_gain[b] <= w_gain_eff[b*GAIN_W +: GAIN_W];
        end
        r_idx <= '0;
        r_acc <= '0;
      end else if (r_state == ST_ACC) begin
        r_acc <= r_acc + w_prod_ext;
        r_idx <= r_idx + 1'b1;
      end else if (r_state == ST_SCALE) begin
        if (w_clip_hi) begin
          r_out_data <= OUT_MAX[DATA_W-1:0];
        end else if (w_clip_lo) begin
          r_out_data <= OUT_MIN[DATA_W-1:0];
        end else begin
          r_out_data <= w_shift[DATA_W-1:0];
        end
        r_sat <= w_clip_hi || w_clip_lo;
      end
    end
  end

  assign out_data = r_out_data;
  assign sat_flag = r_sat;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer at default parameters; expectations come from a bench-side gain/mix model.
module tb_eq_band_mixer;

  localparam int     NB   = 3;
  localparam int     DW   = 24;
  localparam int     GW   = 8;
  localparam int     GF   = 7;
  localparam longint DMAX = 8388607;
  localparam longint DMIN = -8388608;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NB*DW-1:0]  band_data;
  logic              in_valid;
  logic              in_ready;
  logic              gain_wr_en;
  logic [1:0]        gain_wr_band;
  logic [GW-1:0]     gain_wr_data;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sat_flag;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  bit     prev_vld = 1'b0;
  longint exp_dat_q[$];
  bit     exp_sat_q[$];
  int     acc_cyc_q[$];
  int     m_tgt[NB];
  int     m_eff[NB];

  eq_band_mixer u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .band_data    (band_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_band (gain_wr_band),
    .gain_wr_data (gain_wr_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor: latency of each result, and scoreboard pop on every output handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && !prev_vld) begin
        if (acc_cyc_q.size() > 0) check_eq("latency", cyc - acc_cyc_q.pop_front(), NB + 2);
        else                      check_eq("spurious_valid", out_valid, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_dat_q.size() > 0) begin
          check_eq("out_data", $signed(out_data), exp_dat_q.pop_front());
          check_eq("sat_flag", sat_flag, exp_sat_q.pop_front());
        end else begin
          check_eq("unexpected_out", out_valid, 0);
        end
      end
      if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
    end
    prev_vld = out_valid;
  end

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_tgt[b] = 1 << GF;
      m_eff[b] = 1 << GF;
    end
  endtask

  task automatic wr_gain(input int b, input int g);
    gain_wr_en   = 1'b1;
    gain_wr_band = b[1:0];
    gain_wr_data = g[GW-1:0];
    @(posedge clk); #1;
    gain_wr_en = 1'b0;
    if (b < NB) m_tgt[b] = g;
  endtask

  // Drives one sample (optionally with a gain write in the same cycle) and pushes its expected result on accept.
  task automatic send(input int s0, input int s1, input int s2,
                      input bit wr = 1'b0, input int wb = 0, input int wd = 0);
    int     s[NB];
    longint acc;
    bit     ok;
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int b = 0; b < NB; b++) band_data[b*DW +: DW] = s[b][DW-1:0];
    in_valid = 1'b1;
    if (wr) begin
      gain_wr_en   = 1'b1;
      gain_wr_band = wb[1:0];
      gain_wr_data = wd[GW-1:0];
    end
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
`ifdef EQ_BAND_MIXER_RAMP_EN
          if (m_eff[b] < m_tgt[b])      m_eff[b] = m_eff[b] + 1;
          else if (m_eff[b] > m_tgt[b]) m_eff[b] = m_eff[b] - 1;
`else
          m_eff[b] = m_tgt[b];
`endif
        end
        acc = 0;
        for (int b = 0; b < NB; b++) acc += longint'(s[b]) * longint'(m_eff[b]);
        acc = (acc + longint'(1 << (GF - 1))) >>> GF;
        if (acc > DMAX)      begin exp_dat_q.push_back(DMAX); exp_sat_q.push_back(1'b1); end
        else if (acc < DMIN) begin exp_dat_q.push_back(DMIN); exp_sat_q.push_back(1'b1); end
        else                 begin exp_dat_q.push_back(acc);  exp_sat_q.push_back(1'b0); end
      end
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    gain_wr_en = 1'b0;
    if (wr && wb < NB) m_tgt[wb] = wd;
    if (!ok) check_eq("accept_timeout", in_ready, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_dat_q.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    check_eq("drain", exp_dat_q.size(), 0);
  endtask

  initial begin
    in_valid     = 1'b0;
    band_data    = '0;
    gain_wr_en   = 1'b0;
    gain_wr_band = '0;
    gain_wr_data = '0;
    out_ready    = 1'b1;
    model_reset();

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_sat_flag", sat_flag, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Unity gains, mixed signs.
    send(1000, 2000, -500);
    drain();

    // Saturation in both directions at maximum gain.
    for (int b = 0; b < NB; b++) wr_gain(b, 255);
    send(8388607, 8388607, 8388607);
    send(-8388608, -8388608, -8388608);
    drain();

    // Round-half-up at the fractional boundary.
    wr_gain(0, 64);
    send(1, 0, 0);
    send(-1, 0, 0);
    drain();
    for (int b = 0; b < NB; b++) wr_gain(b, 128);

    // Output backpressure: result held, no new accept until handshake.
    out_ready = 1'b0;
    send(300, -100, 50);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    for (int b = 0; b < NB; b++) band_data[b*DW +: DW] = DW'(b * 7 + 5);
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_data", $signed(out_data), exp_dat_q[0]);
      check_eq("bp_sat_flag", sat_flag, exp_sat_q[0]);
      check_eq("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(5, 12, 19);
    drain();

    // Gain write while a sample is in flight only affects the next sample.
    send(1000, 0, 0);
    wr_gain(0, 0);
    send(1000, 0, 0);
    drain();

    // Write coincident with accept: snapshot sees the pre-write gain.
    send(400, 0, 0, 1'b1, 0, 128);
    send(400, 0, 0);
    drain();

    // Out-of-range band index is ignored.
    wr_gain(3, 0);
    send(10, 20, 30);
    drain();

    // Reset during ACC discards the sample and restores unity gains.
    wr_gain(1, 10);
    send(1000, 2000, -500);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    exp_dat_q.delete();
    exp_sat_q.delete();
    acc_cyc_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      check_eq("post_rst_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    send(1000, 2000, -500);
    drain();

    // Gain step from unity toward 0x84 (ramped or immediate depending on build).
    wr_gain(0, 132);
    for (int k = 0; k < 5; k++) send(128, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
